// File: rtl/simon_autoplayer.sv
// simon_autoplayer: automated opponent for the simon game core. Records the colour
//   sequence the game shows on its LEDs, then replays it on the button inputs.
// Latency: an LED change is recorded 3 clk after the pin edge (2-flop sync + edge detect);
//   replay begins IDLE_MS ms after the LEDs go dark; press/gap timing is ms-accurate to -1 ms.
// Backpressure: none; the game core is paced only through the ms-based press/gap timing.
//
// Ports:
//   clk_i             system clock
//   rst_ni            asynchronous active-low reset
//   enable_i          autoplay enable; low forces IDLE and clears the recorded round
//   ticks_per_milli_i clk cycles per ms (0 behaves as 1)
//   led_i             game-core LEDs, asynchronous to clk_i
//   btn_o             button drive to the game core, one-hot or zero
//   seq_len_o         number of entries recorded this round
//   busy_o            high whenever not IDLE
//   overflow_o        sticky: an entry was dropped because the buffer was full
module simon_autoplayer #(
  parameter int MAX_LEN  = 32,
  parameter int PRESS_MS = 300,
  parameter int GAP_MS   = 200,
  parameter int IDLE_MS  = 800
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [15:0] ticks_per_milli_i,
  input  logic [3:0]  led_i,
  output logic [3:0]  btn_o,
  output logic [5:0]  seq_len_o,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int MS_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LISTEN,
    S_PRESS,
    S_GAP,
    S_COOL
  } state_t;

  state_t          state_q;
  logic [3:0]      led_m_q, led_s_q, led_p_q;
  logic [15:0]     presc_q;
  logic [MS_W-1:0] ms_q;
  logic [5:0]      seq_len_q;
  logic [5:0]      ptr_q;
  logic [3:0]      btn_q;
  logic            ovf_q;
  logic [1:0]      mem_q [MAX_LEN];

  // ---------------------------------------------------------------------------
  // LED synchroniser and one-cycle delayed copy for change detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_m_q <= 4'b0;
      led_s_q <= 4'b0;
      led_p_q <= 4'b0;
    end else begin
      led_m_q <= led_i;
      led_s_q <= led_m_q;
      led_p_q <= led_s_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Millisecond prescaler. The >= compare lets a reduced ticks_per_milli take
  // effect at once instead of running the counter round its full range.
  // ---------------------------------------------------------------------------
  logic [15:0] tpm_lim;
  logic        busy;
  logic        ms_tick;

  assign tpm_lim = (ticks_per_milli_i == 16'd0) ? 16'd0 : (ticks_per_milli_i - 16'd1);
  assign busy    = (state_q != S_IDLE);
  assign ms_tick = busy && (presc_q >= tpm_lim);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= 16'd0;
    end else if (!busy || ms_tick) begin
      presc_q <= 16'd0;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // LED decode
  // ---------------------------------------------------------------------------
  logic       led_onehot;
  logic [1:0] led_idx;
  logic       led_dark;
  logic       rec_evt;
  logic       seq_full;
  logic       rec_wr;

  always_comb begin
    led_onehot = 1'b0;
    led_idx    = 2'd0;
    case (led_s_q)
      4'b0001: begin led_onehot = 1'b1; led_idx = 2'd0; end
      4'b0010: begin led_onehot = 1'b1; led_idx = 2'd1; end
      4'b0100: begin led_onehot = 1'b1; led_idx = 2'd2; end
      4'b1000: begin led_onehot = 1'b1; led_idx = 2'd3; end
      default: begin led_onehot = 1'b0; led_idx = 2'd0; end
    endcase
  end

  assign led_dark = (led_s_q == 4'b0);
  assign rec_evt  = led_onehot && (led_s_q != led_p_q);
  assign seq_full = (seq_len_q == 6'(MAX_LEN));
  assign rec_wr   = enable_i && (state_q == S_LISTEN) && rec_evt && !seq_full;

  // ---------------------------------------------------------------------------
  // Sequence buffer: contents are only read below seq_len, so no reset needed
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rec_wr) begin
      mem_q[seq_len_q[IDX_W-1:0]] <= led_idx;
    end
  end

  logic [5:0] ptr_inc;
  logic [1:0] first_idx;
  logic [1:0] next_idx;

  assign ptr_inc   = ptr_q + 6'd1;
  assign first_idx = mem_q[0];
  // Only consumed when ptr_inc < seq_len, so the truncated index is in range.
  assign next_idx  = mem_q[ptr_inc[IDX_W-1:0]];

  function automatic logic [3:0] btn_of(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM. ms_q doubles as the dark counter (LISTEN), hold/release timer
  // (PRESS/GAP) and quiet timer (COOLDOWN); it is cleared on every state entry.
  // Transitions fire on the tick that would make the count reach its target.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      ms_q      <= '0;
      seq_len_q <= 6'd0;
      ptr_q     <= 6'd0;
      btn_q     <= 4'b0;
      ovf_q     <= 1'b0;
    end else if (!enable_i) begin
      // Overflow deliberately survives a disable so self-test can read it.
      state_q   <= S_IDLE;
      ms_q      <= '0;
      seq_len_q <= 6'd0;
      ptr_q     <= 6'd0;
      btn_q     <= 4'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q   <= S_LISTEN;
          ms_q      <= '0;
          seq_len_q <= 6'd0;
          btn_q     <= 4'b0;
        end

        S_LISTEN: begin
          if (rec_evt) begin
            if (seq_full) ovf_q <= 1'b1;
            else          seq_len_q <= seq_len_q + 6'd1;
          end
          // Lit (any pattern) or nothing recorded yet: the dark time does not count.
          if (!led_dark || (seq_len_q == 6'd0)) begin
            ms_q <= '0;
          end else if (ms_tick) begin
            if (ms_q == MS_W'(IDLE_MS - 1)) begin
              state_q <= S_PRESS;
              ms_q    <= '0;
              ptr_q   <= 6'd0;
              btn_q   <= btn_of(first_idx);
            end else begin
              ms_q <= ms_q + 1'b1;
            end
          end
        end

        S_PRESS: begin
          if (ms_tick) begin
            if (ms_q == MS_W'(PRESS_MS - 1)) begin
              state_q <= S_GAP;
              ms_q    <= '0;
              btn_q   <= 4'b0;
            end else begin
              ms_q <= ms_q + 1'b1;
            end
          end
        end

        S_GAP: begin
          if (ms_tick) begin
            if (ms_q == MS_W'(GAP_MS - 1)) begin
              ms_q <= '0;
              if (ptr_inc < seq_len_q) begin
                state_q <= S_PRESS;
                ptr_q   <= ptr_inc;
                btn_q   <= btn_of(next_idx);
              end else begin
                state_q <= S_COOL;
              end
            end else begin
              ms_q <= ms_q + 1'b1;
            end
          end
        end

        S_COOL: begin
          // Wait for the game's echo/result display to finish before listening again.
          if (!led_dark) begin
            ms_q <= '0;
          end else if (ms_tick) begin
            if (ms_q == MS_W'(GAP_MS - 1)) begin
              state_q   <= S_LISTEN;
              ms_q      <= '0;
              seq_len_q <= 6'd0;
            end else begin
              ms_q <= ms_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          ms_q    <= '0;
          btn_q   <= 4'b0;
        end
      endcase
    end
  end

  assign btn_o      = btn_q;
  assign seq_len_o  = seq_len_q;
  assign busy_o     = busy;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// tb_simon_autoplayer: directed bench for simon_autoplayer with shortened timing
//   (MAX_LEN=4, PRESS_MS=3, GAP_MS=2, IDLE_MS=5) so every expectation is hand-derivable.
// With ticks_per_milli=4: press = 12 clk, gap = 8 clk, replay starts ~20 clk after dark.
module tb_simon_autoplayer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] tpm;
  logic [3:0]  led;
  logic [3:0]  btn;
  logic [5:0]  seq_len;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  int waited;
  int n;

  always #5 clk = ~clk;

  simon_autoplayer #(
    .MAX_LEN (4),
    .PRESS_MS(3),
    .GAP_MS  (2),
    .IDLE_MS (5)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .ticks_per_milli_i(tpm),
    .led_i            (led),
    .btn_o            (btn),
    .seq_len_o        (seq_len),
    .busy_o           (busy),
    .overflow_o       (overflow)
  );

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One colour as the game shows it: lit 20 clk, then dark 8 clk.
  task automatic show(input logic [3:0] c);
    led = c;
    step(20);
    led = 4'b0;
    step(8);
  endtask

  // Wait (bounded) for a press, check its colour and optionally its length.
  // Returns the number of dark-button cycles seen before the press started.
  task automatic expect_press(input string tag, input logic [3:0] exp_val,
                              input int exp_len, input int budget, output int wt);
    int         len;
    logic [3:0] v;
    wt = 0;
    while (btn == 4'b0 && wt < budget) begin
      step(1);
      wt++;
    end
    chk({tag, "_btn"}, {28'b0, btn}, {28'b0, exp_val});
    if (exp_len > 0) begin
      v   = btn;
      len = 0;
      while (btn == v && v != 4'b0 && len < 200) begin
        step(1);
        len++;
      end
      chk({tag, "_len"}, len, exp_len);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    tpm    = 16'd4;
    led    = 4'b0;
    #1;
    chk("rst_btn",  {28'b0, btn}, 32'd0);
    chk("rst_len",  {26'b0, seq_len}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ovf",  {31'b0, overflow}, 32'd0);
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("dis_busy", {31'b0, busy}, 32'd0);
    enable = 1'b1;
    step(1);
    chk("en_busy", {31'b0, busy}, 32'd1);
    step(2);

    // ---- T1: two colours, replay with exact press/gap lengths ----
    show(4'b0001);
    chk("t1_len1", {26'b0, seq_len}, 32'd1);
    show(4'b0100);
    chk("t1_len2", {26'b0, seq_len}, 32'd2);
    expect_press("t1_p0", 4'b0001, 12, 40, waited);
    chk_rng("t1_dark", waited, 10, 15);
    expect_press("t1_p1", 4'b0100, 12, 40, waited);
    chk("t1_gap", waited, 32'd8);
    chk("t1_cool_len", {26'b0, seq_len}, 32'd2);
    step(24);
    chk("t1_cleared", {26'b0, seq_len}, 32'd0);
    chk("t1_busy", {31'b0, busy}, 32'd1);

    // ---- T2: next round, three colours ----
    show(4'b0001);
    show(4'b0100);
    show(4'b1000);
    chk("t2_len", {26'b0, seq_len}, 32'd3);
    expect_press("t2_p0", 4'b0001, 12, 40, waited);
    expect_press("t2_p1", 4'b0100, 12, 40, waited);
    chk("t2_gap1", waited, 32'd8);
    expect_press("t2_p2", 4'b1000, 12, 40, waited);
    chk("t2_gap2", waited, 32'd8);
    step(24);
    chk("t2_cleared", {26'b0, seq_len}, 32'd0);

    // ---- T3: back-to-back colours, non-one-hot pattern clears dark time ----
    led = 4'b0010;
    step(20);
    led = 4'b1000;
    step(20);
    chk("t3_len", {26'b0, seq_len}, 32'd2);
    led = 4'b0;
    step(12);
    led = 4'b0110;
    step(4);
    chk("t3_nohot_btn", {28'b0, btn}, 32'd0);
    chk("t3_nohot_len", {26'b0, seq_len}, 32'd2);
    led = 4'b0;
    step(8);
    expect_press("t3_p0", 4'b0010, 12, 40, waited);
    chk_rng("t3_dark", waited, 10, 15);
    expect_press("t3_p1", 4'b1000, 12, 40, waited);
    chk("t3_gap", waited, 32'd8);
    step(24);

    // ---- T4: five colours into a 4-entry buffer ----
    chk("t4_ovf0", {31'b0, overflow}, 32'd0);
    show(4'b0001);
    show(4'b0010);
    show(4'b0100);
    show(4'b1000);
    chk("t4_full_len", {26'b0, seq_len}, 32'd4);
    chk("t4_full_ovf", {31'b0, overflow}, 32'd0);
    show(4'b0001);
    chk("t4_len", {26'b0, seq_len}, 32'd4);
    chk("t4_ovf", {31'b0, overflow}, 32'd1);
    expect_press("t4_p0", 4'b0001, 12, 40, waited);
    expect_press("t4_p1", 4'b0010, 12, 40, waited);
    expect_press("t4_p2", 4'b0100, 12, 40, waited);
    expect_press("t4_p3", 4'b1000, 12, 40, waited);
    n = 0;
    while (btn == 4'b0 && n < 40) begin
      step(1);
      n++;
    end
    chk("t4_no_p4", n, 32'd40);
    chk("t4_cleared", {26'b0, seq_len}, 32'd0);

    // ---- T6a: game echo during PRESS is not recorded ----
    show(4'b0010);
    expect_press("t6_p0", 4'b0010, 0, 40, waited);
    led = 4'b0100;
    step(6);
    chk("t6_echo_len", {26'b0, seq_len}, 32'd1);
    chk("t6_echo_btn", {28'b0, btn}, 32'h2);
    led = 4'b0;
    step(40);
    chk("t6_cleared", {26'b0, seq_len}, 32'd0);

    // ---- T6b: ticks_per_milli=0 behaves as 1 ----
    tpm = 16'd0;
    led = 4'b0001;
    step(20);
    led = 4'b0;
    expect_press("t6z_p0", 4'b0001, 3, 40, waited);
    step(20);
    tpm = 16'd4;
    step(5);

    // ---- T5a: enable dropped mid-PRESS ----
    show(4'b0001);
    expect_press("t5_p0", 4'b0001, 0, 40, waited);
    step(2);
    enable = 1'b0;
    step(1);
    chk("t5_dis_btn",  {28'b0, btn}, 32'd0);
    chk("t5_dis_busy", {31'b0, busy}, 32'd0);
    chk("t5_dis_len",  {26'b0, seq_len}, 32'd0);
    chk("t5_dis_ovf",  {31'b0, overflow}, 32'd1);
    enable = 1'b1;
    step(2);
    chk("t5_reen_busy", {31'b0, busy}, 32'd1);

    // ---- T5b: asynchronous reset mid-GAP ----
    show(4'b0001);
    expect_press("t5_p1", 4'b0001, 12, 40, waited);
    step(2);
    chk("t5_gap_len", {26'b0, seq_len}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_arst_len",  {26'b0, seq_len}, 32'd0);
    chk("t5_arst_busy", {31'b0, busy}, 32'd0);
    chk("t5_arst_ovf",  {31'b0, overflow}, 32'd0);
    chk("t5_arst_btn",  {28'b0, btn}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
